// File: rtl/sysbus_bridge_if.sv
// Bundles the CPU register port and the per-slave strobe/ack bus of sysbus_bridge.
// The bridge uses the slave modport. The environment (CPU decoder, slave cores) uses the master modport.
interface sysbus_bridge_if #(
  parameter int NSLV = 2
);
  logic              cs;
  logic              we;
  logic [7:0]        addr;
  logic [7:0]        din;
  logic [7:0]        dout;
  logic              rdy;
  logic              irq;
  logic [NSLV-1:0]   wb_stb;
  logic              wb_we;
  logic [7:0]        wb_adr;
  logic [7:0]        wb_dato;
  logic [8*NSLV-1:0] wb_dati;
  logic [NSLV-1:0]   wb_ack;
  logic [NSLV-1:0]   slv_irq;

  modport slave (
    input  cs, we, addr, din, wb_dati, wb_ack, slv_irq,
    output dout, rdy, irq, wb_stb, wb_we, wb_adr, wb_dato
  );

  modport master (
    output cs, we, addr, din, wb_dati, wb_ack, slv_irq,
    input  dout, rdy, irq, wb_stb, wb_we, wb_adr, wb_dato
  );
endinterface

// File: rtl/sysbus_bridge.sv
// Bridges Z80 register accesses to NSLV strobe/ack slaves, holds the CPU on rdy, and masks slave interrupts.
// Defining SYSBUS_TIMEOUT_EN adds a strobe timeout that aborts the access and sets the sticky STATUS.TO flag.
module sysbus_bridge #(
  parameter int NSLV    = 2,
  parameter int TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst,
  sysbus_bridge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, STROBE, DONE} state_e;

  state_e          state_q, state_d;
  logic            cs_q;
  logic            start, slaveTgt, localTgt, localWr;
  logic [2:0]      chan_q;
  logic [NSLV-1:0] sel, stb;
  logic            ackHit, expire, toFlag, rdy;
  logic [7:0]      rdata, localRead, irqRaw;
  logic [7:0]      irqMask_q, dout_q, wbAdr_q, wbDato_q;
  logic            wbWe_q, irq_q;

  if (NSLV < 1 || NSLV > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_badParam
    $error("sysbus_bridge: NSLV must be 1..8 and TIMEOUT 1..255");
  end

  assign start    = bus.cs & ~cs_q;
  assign slaveTgt = bus.addr[7:4] < 4'(NSLV);
  assign localTgt = bus.addr[7:4] == 4'hF;
  assign localWr  = start & localTgt & bus.we;
  assign sel      = NSLV'(1) << chan_q;
  assign ackHit   = |(bus.wb_ack & sel);

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel[i]) rdata = bus.wb_dati[8*i +: 8];
    end
  end

  always_comb begin
    irqRaw = '0;
    irqRaw[NSLV-1:0] = bus.slv_irq;
  end

  always_comb begin
    localRead = 8'h00;
    case (bus.addr[3:0])
      4'h0:    localRead = irqRaw;
      4'h1:    localRead = irqMask_q;
      4'h2:    localRead = {7'b0, toFlag};
      default: localRead = 8'h00;
    endcase
  end

`ifdef SYSBUS_TIMEOUT_EN
  // The counter is 0 in the first strobe cycle, so the last permitted strobe cycle sees TIMEOUT-1.
  localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);
  logic [7:0] count_q;
  logic       to_q;

  assign expire = (state_q == STROBE) & ~ackHit & (count_q == LastCount);
  assign toFlag = to_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      to_q    <= 1'b0;
    end else begin
      count_q <= (state_q == STROBE) ? count_q + 8'd1 : 8'd0;
      if (expire)
        to_q <= 1'b0 | 1'b1;
      else if (localWr && bus.addr[3:0] == 4'h2 && bus.din[0])
        to_q <= 1'b0;
    end
  end
`else
  assign expire = 1'b0;
  assign toFlag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && slaveTgt) state_d = STROBE;
      STROBE:  if (ackHit || expire)  state_d = DONE;
      DONE:    if (!bus.cs)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Both outputs are combinational so the CPU stall starts in the same cycle that cs rises.
  always_comb begin
    stb = '0;
    if (state_q == STROBE) stb = sel;
    rdy = ~((start & slaveTgt) | (state_q == STROBE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q      <= 1'b0;
      chan_q    <= '0;
      wbAdr_q   <= '0;
      wbDato_q  <= '0;
      wbWe_q    <= 1'b0;
      dout_q    <= '0;
      irqMask_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      cs_q  <= bus.cs;
      irq_q <= |(bus.slv_irq & irqMask_q[NSLV-1:0]);
      if (start) begin
        if (slaveTgt && state_q == IDLE) begin
          chan_q   <= bus.addr[6:4];
          wbAdr_q  <= bus.addr;
          wbDato_q <= bus.din;
          wbWe_q   <= bus.we;
        end else if (localTgt && !bus.we) begin
          dout_q <= localRead;
        end else if (!slaveTgt && !localTgt && !bus.we) begin
          dout_q <= 8'h00;
        end
      end
      if (localWr && bus.addr[3:0] == 4'h1) irqMask_q <= bus.din;
      if (state_q == STROBE && !wbWe_q) begin
        if (ackHit)      dout_q <= rdata;
        else if (expire) dout_q <= 8'hFF;
      end
    end
  end

  assign bus.dout    = dout_q;
  assign bus.rdy     = rdy;
  assign bus.irq     = irq_q;
  assign bus.wb_stb  = stb;
  assign bus.wb_we   = wbWe_q;
  assign bus.wb_adr  = wbAdr_q;
  assign bus.wb_dato = wbDato_q;

endmodule

// File: tb/tb_sysbus_bridge.sv
// Directed self-checking bench for sysbus_bridge with NSLV=2 and TIMEOUT=15.
// The timeout scenario expects an abort when SYSBUS_TIMEOUT_EN is defined and an indefinite stall otherwise.
module tb_sysbus_bridge;
  localparam int NSLV    = 2;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  sysbus_bridge_if #(.NSLV(NSLV)) bus();

  sysbus_bridge #(.NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge. Checks sample 1 time unit after that.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.din = 8'h00;
    bus.wb_dati = '0; bus.wb_ack = '0; bus.slv_irq = '0;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.dout, bus.rdy, bus.irq, bus.wb_stb, bus.wb_we, bus.wb_adr, bus.wb_dato}
        !== {8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00}) begin
      fails++;
      $display("[TB] FAIL reset_outputs got %h exp %h",
               {bus.dout, bus.rdy, bus.irq, bus.wb_stb, bus.wb_we, bus.wb_adr, bus.wb_dato},
               {8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00});
    end
  endtask

  task automatic test_read();
    cyc(); bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 8'h05; #1;
    checks++; if (bus.rdy !== 1'b0) begin fails++; $display("[TB] FAIL read_rdy_c0 got %b exp 0", bus.rdy); end
    cyc(); #1;
    checks++; if (bus.wb_stb !== 2'b01) begin fails++; $display("[TB] FAIL read_stb_c1 got %b exp 01", bus.wb_stb); end
    checks++; if ({bus.wb_adr, bus.wb_we} !== {8'h05, 1'b0}) begin
      fails++; $display("[TB] FAIL read_adr_we got %h/%b exp 05/0", bus.wb_adr, bus.wb_we); end
    checks++; if (bus.rdy !== 1'b0) begin fails++; $display("[TB] FAIL read_rdy_c1 got %b exp 0", bus.rdy); end
    cyc(); #1;
    checks++; if (bus.rdy !== 1'b0) begin fails++; $display("[TB] FAIL read_rdy_c2 got %b exp 0", bus.rdy); end
    cyc(); bus.wb_ack = 2'b01; bus.wb_dati = 16'h00A5; #1;
    checks++; if ({bus.rdy, bus.wb_stb} !== {1'b0, 2'b01}) begin
      fails++; $display("[TB] FAIL read_c3 got rdy=%b stb=%b exp rdy=0 stb=01", bus.rdy, bus.wb_stb); end
    cyc(); bus.wb_ack = 2'b00; #1;
    checks++; if ({bus.rdy, bus.wb_stb} !== {1'b1, 2'b00}) begin
      fails++; $display("[TB] FAIL read_c4 got rdy=%b stb=%b exp rdy=1 stb=00", bus.rdy, bus.wb_stb); end
    checks++; if (bus.dout !== 8'hA5) begin fails++; $display("[TB] FAIL read_dout got %h exp a5", bus.dout); end
    cyc(); bus.cs = 1'b0;
  endtask

  task automatic test_write();
    cyc(); bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 8'h12; bus.din = 8'h3C; #1;
    checks++; if (bus.rdy !== 1'b0) begin fails++; $display("[TB] FAIL write_rdy_c0 got %b exp 0", bus.rdy); end
    cyc(); bus.wb_ack = 2'b10; #1;
    checks++; if ({bus.wb_stb, bus.wb_dato, bus.wb_we} !== {2'b10, 8'h3C, 1'b1}) begin
      fails++; $display("[TB] FAIL write_c1 got stb=%b dato=%h we=%b exp stb=10 dato=3c we=1",
                        bus.wb_stb, bus.wb_dato, bus.wb_we); end
    cyc(); bus.wb_ack = 2'b00; #1;
    checks++; if ({bus.wb_stb, bus.rdy, bus.dout} !== {2'b00, 1'b1, 8'hA5}) begin
      fails++; $display("[TB] FAIL write_c2 got stb=%b rdy=%b dout=%h exp stb=00 rdy=1 dout=a5",
                        bus.wb_stb, bus.rdy, bus.dout); end
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      checks++; if ({bus.wb_stb, bus.rdy} !== {2'b00, 1'b1}) begin
        fails++; $display("[TB] FAIL write_held_cs got stb=%b rdy=%b exp stb=00 rdy=1", bus.wb_stb, bus.rdy); end
    end
    cyc(); bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic test_stray_ack();
    cyc(); bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 8'h00; bus.wb_dati = 16'h115A;
    cyc(); bus.wb_ack = 2'b10;
    cyc(); bus.wb_ack = 2'b00; #1;
    checks++; if ({bus.wb_stb, bus.rdy} !== {2'b01, 1'b0}) begin
      fails++; $display("[TB] FAIL stray_ignored got stb=%b rdy=%b exp stb=01 rdy=0", bus.wb_stb, bus.rdy); end
    cyc(); bus.wb_ack = 2'b01;
    cyc(); bus.wb_ack = 2'b00; #1;
    checks++; if ({bus.wb_stb, bus.rdy, bus.dout} !== {2'b00, 1'b1, 8'h5A}) begin
      fails++; $display("[TB] FAIL stray_complete got stb=%b rdy=%b dout=%h exp stb=00 rdy=1 dout=5a",
                        bus.wb_stb, bus.rdy, bus.dout); end
    cyc(); bus.cs = 1'b0;
  endtask

  task automatic test_null();
    cyc(); bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 8'h80; #1;
    checks++; if ({bus.wb_stb, bus.rdy} !== {2'b00, 1'b1}) begin
      fails++; $display("[TB] FAIL null_c0 got stb=%b rdy=%b exp stb=00 rdy=1", bus.wb_stb, bus.rdy); end
    cyc(); bus.cs = 1'b0; #1;
    checks++; if ({bus.wb_stb, bus.rdy, bus.dout} !== {2'b00, 1'b1, 8'h00}) begin
      fails++; $display("[TB] FAIL null_c1 got stb=%b rdy=%b dout=%h exp stb=00 rdy=1 dout=00",
                        bus.wb_stb, bus.rdy, bus.dout); end
  endtask

  task automatic test_irq();
    cyc(); bus.slv_irq = 2'b11;
    cyc(); #1;
    checks++; if (bus.irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_masked got %b exp 0", bus.irq); end
    cyc(); bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 8'hF0; #1;
    checks++; if (bus.rdy !== 1'b1) begin fails++; $display("[TB] FAIL local_rdy got %b exp 1", bus.rdy); end
    cyc(); bus.cs = 1'b0; #1;
    checks++; if (bus.dout !== 8'h03) begin fails++; $display("[TB] FAIL irq_raw got %h exp 03", bus.dout); end
    cyc(); bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 8'hF1; bus.din = 8'h02;
    cyc(); bus.cs = 1'b0; bus.we = 1'b0; #1;
    checks++; if (bus.irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_mask_c1 got %b exp 0", bus.irq); end
    cyc(); #1;
    checks++; if (bus.irq !== 1'b1) begin fails++; $display("[TB] FAIL irq_mask_c2 got %b exp 1", bus.irq); end
    cyc(); bus.cs = 1'b1; bus.addr = 8'hF1;
    cyc(); bus.cs = 1'b0; #1;
    checks++; if (bus.dout !== 8'h02) begin fails++; $display("[TB] FAIL irq_mask_read got %h exp 02", bus.dout); end
    cyc(); bus.slv_irq = 2'b01; #1;
    checks++; if (bus.irq !== 1'b1) begin fails++; $display("[TB] FAIL irq_drop_c0 got %b exp 1", bus.irq); end
    cyc(); #1;
    checks++; if (bus.irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_drop_c1 got %b exp 0", bus.irq); end
    cyc(); bus.slv_irq = 2'b11;
  endtask

  task automatic test_timeout();
    cyc(); bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 8'h00; bus.wb_ack = 2'b00;
    for (int i = 1; i <= TIMEOUT; i++) begin
      cyc(); #1;
      checks++; if ({bus.wb_stb, bus.rdy} !== {2'b01, 1'b0}) begin
        fails++; $display("[TB] FAIL timeout_strobe cycle %0d got stb=%b rdy=%b exp stb=01 rdy=0",
                          i, bus.wb_stb, bus.rdy); end
    end
`ifdef SYSBUS_TIMEOUT_EN
    cyc(); #1;
    checks++; if ({bus.wb_stb, bus.rdy, bus.dout} !== {2'b00, 1'b1, 8'hFF}) begin
      fails++; $display("[TB] FAIL timeout_abort got stb=%b rdy=%b dout=%h exp stb=00 rdy=1 dout=ff",
                        bus.wb_stb, bus.rdy, bus.dout); end
    cyc(); bus.cs = 1'b0;
    cyc(); bus.cs = 1'b1; bus.addr = 8'hF2;
    cyc(); bus.cs = 1'b0; #1;
    checks++; if (bus.dout !== 8'h01) begin fails++; $display("[TB] FAIL status_set got %h exp 01", bus.dout); end
    cyc(); bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 8'hF2; bus.din = 8'h01;
    cyc(); bus.cs = 1'b0; bus.we = 1'b0;
    cyc(); bus.cs = 1'b1; bus.addr = 8'hF2;
    cyc(); bus.cs = 1'b0; #1;
    checks++; if (bus.dout !== 8'h00) begin fails++; $display("[TB] FAIL status_clear got %h exp 00", bus.dout); end
`else
    repeat (90) cyc();
    #1;
    checks++; if ({bus.wb_stb, bus.rdy} !== {2'b01, 1'b0}) begin
      fails++; $display("[TB] FAIL stall_persists got stb=%b rdy=%b exp stb=01 rdy=0", bus.wb_stb, bus.rdy); end
    cyc(); bus.cs = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    cyc(); bus.cs = 1'b1; bus.addr = 8'hF2;
    cyc(); bus.cs = 1'b0; #1;
    checks++; if (bus.dout !== 8'h00) begin fails++; $display("[TB] FAIL status_no_to got %h exp 00", bus.dout); end
`endif
  endtask

  task automatic test_reset_mid();
    cyc(); bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 8'hF1; bus.din = 8'h02;
    cyc(); bus.cs = 1'b0; bus.we = 1'b0;
    cyc(); #1;
    checks++; if (bus.irq !== 1'b1) begin fails++; $display("[TB] FAIL pre_reset_irq got %b exp 1", bus.irq); end
    cyc(); bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 8'h01; bus.wb_dati = 16'h0077;
    cyc(); #1;
    checks++; if (bus.wb_stb !== 2'b01) begin fails++; $display("[TB] FAIL mid_stb got %b exp 01", bus.wb_stb); end
    cyc(); rst = 1'b1; bus.cs = 1'b0;
    cyc(); rst = 1'b0; bus.wb_ack = 2'b01; #1;
    checks++;
    if ({bus.dout, bus.rdy, bus.irq, bus.wb_stb, bus.wb_we, bus.wb_adr, bus.wb_dato}
        !== {8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00}) begin
      fails++;
      $display("[TB] FAIL mid_reset_outputs got %h exp %h",
               {bus.dout, bus.rdy, bus.irq, bus.wb_stb, bus.wb_we, bus.wb_adr, bus.wb_dato},
               {8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00});
    end
    cyc(); bus.wb_ack = 2'b00; #1;
    checks++; if ({bus.wb_stb, bus.dout, bus.irq} !== {2'b00, 8'h00, 1'b0}) begin
      fails++; $display("[TB] FAIL late_ack_ignored got stb=%b dout=%h irq=%b exp stb=00 dout=00 irq=0",
                        bus.wb_stb, bus.dout, bus.irq); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_stray_ack();
    test_null();
    test_irq();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence finished");
    $fatal(1, "[TB] watchdog");
  end
endmodule

// File: doc/sysbus_bridge.md
# sysbus_bridge

Parametrised CPU-to-system-bus bridge: converts Z80 peripheral register accesses into strobe/ack transactions toward up to NSLV on-chip slave cores (SB_SPI/SB_I2C-style hard IP or fabric cores). It holds the CPU with `rdy` until the slave acknowledges, and can abort hung transactions with a timeout. It also aggregates per-slave interrupt lines through a mask register into one CPU `irq`. It is the successor to the single-slave wishbone wrapper and sits between the CPU I/O decoder and the peripheral cores.

## Interface
- NSLV, 2, number of slave channels, 1..8
- TIMEOUT, 15, strobe cycles without ack before abort, 1..255

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cs  in  1  chip select from CPU I/O decode, high-true
- we  in  1  CPU write enable, high-true
- addr  in  8  CPU register address; [7:4] channel, [3:0] register
- din  in  8  CPU write data
- dout  out  8  CPU read data, registered
- rdy  out  1  high = CPU may proceed, low = stall
- irq  out  1  high-true interrupt request, registered
- wb_stb  out  NSLV  per-slave strobe, one-hot or zero
- wb_we  out  1  bus write enable
- wb_adr  out  8  bus address, = addr
- wb_dato  out  8  bus write data
- wb_dati  in  8*NSLV  slave read data; slave k on [8k+7:8k]
- wb_ack  in  NSLV  per-slave acknowledge
- slv_irq  in  NSLV  per-slave interrupt, high-true level

## Operation
- Start event: `start = cs & ~cs_q`, where cs_q is cs registered, reset 0. Only rising cs starts an access; a held cs never retriggers.
- Decode of addr[7:4] = k:
  - k < NSLV: slave access.
  - k = 0xF: local register.
  - Any other k: null access. No strobe, no stall. A read returns 0x00; a write is dropped.
- Local registers:
  - 0xF0 IRQ_RAW, read-only: slv_irq, zero-extended.
  - 0xF1 IRQ_MASK, RW, reset 0.
  - 0xF2 STATUS: bit0 TO, a sticky timeout flag. Writing with bit0=1 clears it. Other bits read 0.
  - 0xF3..0xFF read 0x00.
- FSM states IDLE, STROBE, DONE:
  - IDLE: on start with a slave target, latch wb_adr, wb_we, wb_dato and k, then go to STROBE.
  - STROBE: hold wb_stb[k]=1, with the counter counting up from 0.
    - On wb_ack[k]: for a read, dout <= wb_dati[k]; for a write, dout is unchanged. Drop wb_stb and go to DONE.
  - DONE: wait for cs=0, then go to IDLE. A new start cannot occur without cs falling first.
- Only the targeted slave's ack is honoured. Acks from other slaves are ignored at all times.
- `rdy = ~((start & slave_target) | state==STROBE)`, combinational, so the stall begins in the same cycle cs rises.
- `irq <= |(slv_irq & IRQ_MASK[NSLV-1:0])`.
- If cs falls during STROBE, the transaction still completes and dout updates.

## Timing
- Reset values: dout=0x00, rdy=1, irq=0, wb_stb=0, wb_we=0, wb_adr=0x00, wb_dato=0x00, IRQ_MASK=0, TO=0, state=IDLE.
- Reset mid-transaction: wb_stb is 0 and state is IDLE after the reset edge. Any late ack is ignored.
- Slave access with start in cycle 0:
  - wb_stb is high from cycle 1.
  - If ack is sampled in cycle n (n≥1), wb_stb is low and dout is valid in cycle n+1.
  - rdy is low in cycles 0..n and high in cycle n+1.
  - Minimum stall is 2 cycles.
- Local and null accesses: dout is valid in cycle 1 and rdy never drops.
- IRQ latency: one cycle from slv_irq or IRQ_MASK change to irq.

## Configuration
- SYSBUS_TIMEOUT_EN defined:
  - In STROBE, if the counter reaches TIMEOUT with no ack, wb_stb drops, a read sets dout=0xFF, TO is set, and the FSM goes to DONE.
  - rdy returns high in cycle TIMEOUT+1.
  - An ack in the same cycle as expiry wins, and TO is not set.
- SYSBUS_TIMEOUT_EN undefined: no counter; STROBE waits indefinitely; STATUS.TO always reads 0.

## Test plan
- Read channel 0 at 0x05, slave acks 3 cycles after wb_stb rises with data 0xA5 -> wb_adr=0x05, wb_we=0; rdy low for 4 cycles; dout=0xA5 when rdy rises; wb_stb one-hot on bit 0.
- Write 0x3C to 0x12 with NSLV≥2, ack on first strobe cycle -> wb_stb[1] high for 1 cycle; wb_dato=0x3C, wb_we=1; dout unchanged; cs held 10 cycles produces no second strobe.
- Timeout with the macro defined and TIMEOUT=15, read to 0x00 with no ack -> wb_stb high 15 cycles; dout=0xFF; STATUS reads 0x01; writing 0x01 to 0xF2 makes it read 0x00. Same run without the macro -> stall persists past 100 cycles.
- IRQ masking: slv_irq=0b11 with mask 0 -> irq=0 and IRQ_RAW=0x03. Write 0x02 to 0xF1 -> irq=1 one cycle later. Drop slv_irq[1] -> irq=0 one cycle later.
- Stray ack from slave 1 during a channel-0 strobe -> ignored; completion only on wb_ack[0]. Assert rst in the 2nd strobe cycle -> all outputs at reset values next cycle.
- Null access to 0x80 with NSLV=2 -> no strobe, rdy stays high, dout=0x00.
